// File: rtl/avalon_mem_arbiter.sv
// Two-master Avalon-MM arbiter: round-robin grant onto one peripheral memory port,
// with a fixed-latency tag pipeline that steers each read response back to its issuer.
module avalon_mem_arbiter #(
    parameter int ADDRWIDTH = 8,
    parameter int DATAWIDTH = 32,
    parameter int LATENCY   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 m0_read,
    input  logic                 m0_write,
    input  logic [ADDRWIDTH-1:0] m0_address,
    input  logic [DATAWIDTH-1:0] m0_data_in,
    output logic                 m0_waitrequest,
    output logic                 m0_read_valid,
    output logic [DATAWIDTH-1:0] m0_data_out,
    input  logic                 m1_read,
    input  logic                 m1_write,
    input  logic [ADDRWIDTH-1:0] m1_address,
    input  logic [DATAWIDTH-1:0] m1_data_in,
    output logic                 m1_waitrequest,
    output logic                 m1_read_valid,
    output logic [DATAWIDTH-1:0] m1_data_out,
    output logic                 s_read,
    output logic                 s_write,
    output logic [ADDRWIDTH-1:0] s_address,
    output logic [DATAWIDTH-1:0] s_data_out,
    input  logic                 s_read_valid,
    input  logic [DATAWIDTH-1:0] s_data_in,
    output logic                 protocol_error
);

    logic                 w_req0;
    logic                 w_req1;
    logic                 w_both;
    logic                 w_issue;
    logic                 w_winner;
    logic                 w_winRead;
    logic                 w_winWrite;
    logic [ADDRWIDTH-1:0] w_winAddr;
    logic [DATAWIDTH-1:0] w_winData;
    logic                 w_lastValid;
    logic                 w_lastId;

    logic                 r_prio;
    logic [LATENCY-1:0]   r_tagValid;
    logic [LATENCY-1:0]   r_tagId;
    logic                 r_protocolError;

    // Nothing is issued while reset is held, so w_issue doubles as "command accepted".
    always_comb begin
        w_req0     = m0_read | m0_write;
        w_req1     = m1_read | m1_write;
        w_both     = w_req0 & w_req1;
        w_issue    = reset & (w_req0 | w_req1);
        w_winner   = w_both ? r_prio : w_req1;
        w_winRead  = w_winner ? m1_read    : m0_read;
        w_winWrite = w_winner ? m1_write   : m0_write;
        w_winAddr  = w_winner ? m1_address : m0_address;
        w_winData  = w_winner ? m1_data_in : m0_data_in;
    end

    assign m0_waitrequest = ~reset | (w_both & w_winner);
    assign m1_waitrequest = ~reset | (w_both & ~w_winner);

    assign s_write    = w_issue & w_winWrite;
    assign s_read     = w_issue & w_winRead & ~w_winWrite;
    assign s_address  = w_issue ? w_winAddr : '0;
    assign s_data_out = w_issue ? w_winData : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prio <= 1'b0;
        end else if (w_issue) begin
            r_prio <= ~w_winner;
        end
    end

    // Stage 0 captures the issuing master; the last stage lines up with s_read_valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tagValid <= '0;
            r_tagId    <= '0;
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                r_tagValid[i] <= r_tagValid[i-1];
                r_tagId[i]    <= r_tagId[i-1];
            end
            r_tagValid[0] <= s_read;
            r_tagId[0]    <= w_winner;
        end
    end

    assign w_lastValid = r_tagValid[LATENCY-1];
    assign w_lastId    = r_tagId[LATENCY-1];

    assign m0_read_valid = s_read_valid & w_lastValid & ~w_lastId;
    assign m1_read_valid = s_read_valid & w_lastValid &  w_lastId;
    assign m0_data_out   = s_data_in;
    assign m1_data_out   = s_data_in;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_protocolError <= 1'b0;
        end else if ((w_issue & w_winRead & w_winWrite) | (s_read_valid ^ w_lastValid)) begin
            r_protocolError <= 1'b1;
        end
    end

    assign protocol_error = r_protocolError;

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Scoreboard bench: two arbiter instances (LATENCY 1 and 3) share master stimulus,
// each with its own fixed-latency peripheral model; monitors pop expected commands/responses.
module tb_avalon_mem_arbiter;

    typedef struct packed {
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic        wait0;
        logic        wait1;
    } cmd_t;

    typedef struct packed {
        logic [1:0]  rv;
        logic [31:0] data;
        logic [31:0] due;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0Read, m0Write, m1Read, m1Write;
    logic [7:0]  m0Address, m1Address;
    logic [31:0] m0DataIn, m1DataIn;
    logic        inject1;

    logic        m0Wait1, m1Wait1, m0Rv1, m1Rv1, sRead1, sWrite1, sRv1, err1;
    logic [31:0] m0Dout1, m1Dout1, sDout1, sDin1;
    logic [7:0]  sAddr1;
    logic        m0Wait3, m1Wait3, m0Rv3, m1Rv3, sRead3, sWrite3, sRv3, err3;
    logic [31:0] m0Dout3, m1Dout3, sDout3, sDin3;
    logic [7:0]  sAddr3;

    logic [31:0] mem [256];
    logic        pv1 = 1'b0;
    logic [31:0] pd1 = '0;
    logic [2:0]  pv3 = '0;
    logic [31:0] pd3 [3];

    logic [31:0] cyc = '0;
    int          testsRun = 0;
    int          failCount = 0;

    cmd_t  cmdQ1[$];
    cmd_t  cmdQ3[$];
    resp_t respQ1[$];
    resp_t respQ3[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    avalon_mem_arbiter #(.ADDRWIDTH(8), .DATAWIDTH(32), .LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .m0_read(m0Read), .m0_write(m0Write), .m0_address(m0Address), .m0_data_in(m0DataIn),
        .m0_waitrequest(m0Wait1), .m0_read_valid(m0Rv1), .m0_data_out(m0Dout1),
        .m1_read(m1Read), .m1_write(m1Write), .m1_address(m1Address), .m1_data_in(m1DataIn),
        .m1_waitrequest(m1Wait1), .m1_read_valid(m1Rv1), .m1_data_out(m1Dout1),
        .s_read(sRead1), .s_write(sWrite1), .s_address(sAddr1), .s_data_out(sDout1),
        .s_read_valid(sRv1), .s_data_in(sDin1), .protocol_error(err1)
    );

    avalon_mem_arbiter #(.ADDRWIDTH(8), .DATAWIDTH(32), .LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .m0_read(m0Read), .m0_write(m0Write), .m0_address(m0Address), .m0_data_in(m0DataIn),
        .m0_waitrequest(m0Wait3), .m0_read_valid(m0Rv3), .m0_data_out(m0Dout3),
        .m1_read(m1Read), .m1_write(m1Write), .m1_address(m1Address), .m1_data_in(m1DataIn),
        .m1_waitrequest(m1Wait3), .m1_read_valid(m1Rv3), .m1_data_out(m1Dout3),
        .s_read(sRead3), .s_write(sWrite3), .s_address(sAddr3), .s_data_out(sDout3),
        .s_read_valid(sRv3), .s_data_in(sDin3), .protocol_error(err3)
    );

    // Peripheral models: no reset, so responses in flight survive a DUT reset as orphans.
    always @(posedge clk) begin
        pv1    <= sRead1;
        pd1    <= mem[sAddr1];
        pv3    <= {pv3[1:0], sRead3};
        pd3[0] <= mem[sAddr3];
        pd3[1] <= pd3[0];
        pd3[2] <= pd3[1];
    end

    assign sRv1  = pv1 | inject1;
    assign sDin1 = pv1 ? pd1 : 32'h0BAD_0BAD;
    assign sRv3  = pv3[2];
    assign sDin3 = pd3[2];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives one cycle of master requests and queues what the hand-computed winner should produce.
    task automatic applyStimulus(input logic r0, input logic w0, input logic [7:0] a0, input logic [31:0] d0,
                                 input logic r1, input logic w1, input logic [7:0] a1, input logic [31:0] d1,
                                 input int expWin, input logic [31:0] expRdData, input logic [1:0] respMask);
        cmd_t  c;
        resp_t r;
        m0Read = r0; m0Write = w0; m0Address = a0; m0DataIn = d0;
        m1Read = r1; m1Write = w1; m1Address = a1; m1DataIn = d1;
        if (expWin >= 0) begin
            c.wr    = (expWin == 1) ? w1 : w0;
            c.rd    = ((expWin == 1) ? r1 : r0) & ~c.wr;
            c.addr  = (expWin == 1) ? a1 : a0;
            c.data  = (expWin == 1) ? d1 : d0;
            c.wait0 = (expWin == 1) && (r0 || w0);
            c.wait1 = (expWin == 0) && (r1 || w1);
            cmdQ1.push_back(c);
            cmdQ3.push_back(c);
            if (c.rd) begin
                r.rv   = (expWin == 1) ? 2'b10 : 2'b01;
                r.data = expRdData;
                if (respMask[0]) begin
                    r.due = cyc + 1;
                    respQ1.push_back(r);
                end
                if (respMask[1]) begin
                    r.due = cyc + 3;
                    respQ3.push_back(r);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 8'h0, 32'h0, 0, 0, 8'h0, 32'h0, -1, 32'h0, 2'b00);
    endtask

    // Command monitors compare every issued s_* command, plus both waitrequests, in that cycle.
    always @(negedge clk) begin
        cmd_t act1, e1;
        if (sRead1 || sWrite1) begin
            act1 = {sRead1, sWrite1, sAddr1, sDout1, m0Wait1, m1Wait1};
            if (cmdQ1.size() == 0) checkOutput("cmd1_unexpected", 64'(act1), 64'd0);
            else begin
                e1 = cmdQ1.pop_front();
                checkOutput("cmd1", 64'(act1), 64'(e1));
            end
        end
    end

    always @(negedge clk) begin
        cmd_t act3, e3;
        if (sRead3 || sWrite3) begin
            act3 = {sRead3, sWrite3, sAddr3, sDout3, m0Wait3, m1Wait3};
            if (cmdQ3.size() == 0) checkOutput("cmd3_unexpected", 64'(act3), 64'd0);
            else begin
                e3 = cmdQ3.pop_front();
                checkOutput("cmd3", 64'(act3), 64'(e3));
            end
        end
    end

    // Response monitors check routing, data and arrival cycle of every read_valid pulse.
    always @(negedge clk) begin
        resp_t er1;
        if (m0Rv1 || m1Rv1) begin
            if (respQ1.size() == 0) checkOutput("rsp1_orphan_routed", 64'({m1Rv1, m0Rv1}), 64'd0);
            else begin
                er1 = respQ1.pop_front();
                checkOutput("rsp1_route", 64'({m1Rv1, m0Rv1}), 64'(er1.rv));
                checkOutput("rsp1_data", 64'(er1.rv[1] ? m1Dout1 : m0Dout1), 64'(er1.data));
                checkOutput("rsp1_cycle", 64'(cyc), 64'(er1.due));
            end
        end
    end

    always @(negedge clk) begin
        resp_t er3;
        if (m0Rv3 || m1Rv3) begin
            if (respQ3.size() == 0) checkOutput("rsp3_orphan_routed", 64'({m1Rv3, m0Rv3}), 64'd0);
            else begin
                er3 = respQ3.pop_front();
                checkOutput("rsp3_route", 64'({m1Rv3, m0Rv3}), 64'(er3.rv));
                checkOutput("rsp3_data", 64'(er3.rv[1] ? m1Dout3 : m0Dout3), 64'(er3.data));
                checkOutput("rsp3_cycle", 64'(cyc), 64'(er3.due));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Alternating-write table: loser holds its command until granted.
    logic [7:0]  wrA0 [7] = '{8'h20, 8'h21, 8'h21, 8'h22, 8'h22, 8'h23, 8'h23};
    logic [31:0] wrD0 [7] = '{32'h100, 32'h101, 32'h101, 32'h102, 32'h102, 32'h103, 32'h103};
    logic        wrV1 [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [7:0]  wrA1 [7] = '{8'h30, 8'h30, 8'h31, 8'h31, 8'h32, 8'h32, 8'h00};
    logic [31:0] wrD1 [7] = '{32'h200, 32'h200, 32'h201, 32'h201, 32'h202, 32'h202, 32'h0};
    int          wrWin[7] = '{0, 1, 0, 1, 0, 1, 0};

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000 + i;
        mem[1] = 32'hA1; mem[2] = 32'hB2; mem[3] = 32'hC3; mem[4] = 32'hD4; mem[5] = 32'hE5;
        pd3[0] = '0; pd3[1] = '0; pd3[2] = '0;
        reset = 1'b0; inject1 = 1'b0;
        m0Read = 0; m0Write = 0; m0Address = 0; m0DataIn = 0;
        m1Read = 0; m1Write = 0; m1Address = 0; m1DataIn = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with both masters requesting
        m0Write = 1; m0Address = 8'h77; m0DataIn = 32'h1234; m1Read = 1; m1Address = 8'h01;
        #1;
        checkOutput("rst_wait0", 64'(m0Wait1), 64'd1);
        checkOutput("rst_wait1", 64'(m1Wait1), 64'd1);
        checkOutput("rst_swrite", 64'(sWrite1), 64'd0);
        checkOutput("rst_sread", 64'(sRead1), 64'd0);
        checkOutput("rst_saddr", 64'(sAddr1), 64'd0);
        checkOutput("rst_sdata", 64'(sDout1), 64'd0);
        checkOutput("rst_err", 64'(err1), 64'd0);
        checkOutput("rst3_wait", 64'({m0Wait3, m1Wait3}), 64'd3);
        m0Write = 0; m0Address = 0; m0DataIn = 0; m1Read = 0; m1Address = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Simultaneous reads out of reset: m0 first, m1 next cycle
        applyStimulus(1, 0, 8'h01, 32'h0, 1, 0, 8'h02, 32'h0, 0, 32'hA1, 2'b11);
        applyStimulus(0, 0, 8'h00, 32'h0, 1, 0, 8'h02, 32'h0, 1, 32'hB2, 2'b11);
        idleCycles(4);

        // Lone write issues in the same cycle
        applyStimulus(0, 1, 8'h10, 32'hDEADBEEF, 0, 0, 8'h00, 32'h0, 0, 32'h0, 2'b00);
        idleCycles(2);

        // Back-to-back reads m1, m0, m1
        applyStimulus(0, 0, 8'h00, 32'h0, 1, 0, 8'h03, 32'h0, 1, 32'hC3, 2'b11);
        applyStimulus(1, 0, 8'h04, 32'h0, 0, 0, 8'h00, 32'h0, 0, 32'hD4, 2'b11);
        applyStimulus(0, 0, 8'h00, 32'h0, 1, 0, 8'h05, 32'h0, 1, 32'hE5, 2'b11);
        idleCycles(5);

        // Continuous contention: strict alternation
        for (int i = 0; i < 7; i++)
            applyStimulus(0, 1, wrA0[i], wrD0[i], 0, wrV1[i], wrA1[i], wrD1[i], wrWin[i], 32'h0, 2'b00);
        idleCycles(3);
        checkOutput("noerr1", 64'(err1), 64'd0);
        checkOutput("noerr3", 64'(err3), 64'd0);

        // Orphan response on the LATENCY=1 instance
        inject1 = 1'b1;
        idleCycles(1);
        inject1 = 1'b0;
        checkOutput("orphan_err1", 64'(err1), 64'd1);
        idleCycles(3);
        checkOutput("orphan_err1_sticky", 64'(err1), 64'd1);
        checkOutput("orphan_err3_clean", 64'(err3), 64'd0);
        reset = 1'b0;
        #1;
        checkOutput("err1_cleared", 64'(err1), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Read in flight across a one-cycle reset: its response becomes an orphan
        applyStimulus(0, 0, 8'h00, 32'h0, 1, 0, 8'h02, 32'h0, 1, 32'hB2, 2'b00);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        idleCycles(3);
        checkOutput("inflight_err3", 64'(err3), 64'd1);
        checkOutput("inflight_err1", 64'(err1), 64'd0);

        // Read and write together: write wins, error flagged
        applyStimulus(0, 0, 8'h00, 32'h0, 1, 1, 8'h40, 32'h55, 1, 32'h0, 2'b00);
        idleCycles(2);
        checkOutput("rdwr_err1", 64'(err1), 64'd1);
        idleCycles(5);

        checkOutput("cmdQ1_left", 64'(cmdQ1.size()), 64'd0);
        checkOutput("cmdQ3_left", 64'(cmdQ3.size()), 64'd0);
        checkOutput("respQ1_left", 64'(respQ1.size()), 64'd0);
        checkOutput("respQ3_left", 64'(respQ3.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/avalon_mem_arbiter.md
Name: avalon_mem_arbiter

Overview:
- Two-requester Avalon-MM arbiter that shares the peripheral's single memory port (read/write/address/data, fixed-latency read_valid) between two masters, e.g. host bus and DMA engine.
- Round-robin grant, one command per cycle, waitrequest back-pressure to the loser.
- A fixed-latency tag pipeline routes each read response back to the master that issued the read.
- Sits between the two master-side buses and the peripheral's mem_* port group.

Parameters:
ADDRWIDTH, 8, address width of all ports (matches 256-deep peripheral memory)
DATAWIDTH, 32, data width of all ports
LATENCY, 1, fixed downstream read latency in cycles (issue to s_read_valid); legal range 1..8

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
m0_read  input  1  master 0 read request
m0_write  input  1  master 0 write request
m0_address  input  ADDRWIDTH  master 0 address
m0_data_in  input  DATAWIDTH  master 0 write data
m0_waitrequest  output  1  high = master 0 command not accepted this cycle
m0_read_valid  output  1  master 0 read data valid
m0_data_out  output  DATAWIDTH  master 0 read data
m1_read, m1_write, m1_address, m1_data_in, m1_waitrequest, m1_read_valid, m1_data_out  (as m0, for master 1)
s_read  output  1  read command to peripheral
s_write  output  1  write command to peripheral
s_address  output  ADDRWIDTH  address to peripheral
s_data_out  output  DATAWIDTH  write data to peripheral
s_read_valid  input  1  peripheral read data valid
s_data_in  input  DATAWIDTH  peripheral read data
protocol_error  output  1  sticky error flag

Behaviour:
- Request: mN_req = mN_read | mN_write.
- Grant (combinational, same cycle):
  - only one master requests -> it wins;
  - both request -> the master named by priority register prio wins.
- prio: reset 0 (m0). On every accepted command, prio <= index of the non-winner. No update on idle cycles.
- Winner: waitrequest=0 and its command is driven onto s_* in the same cycle (zero-cycle issue). Loser: waitrequest=1 and must hold its command.
- Idle master: waitrequest=0, so a new request is not blocked until contention.
- Both masters continuously requesting -> strict alternation, no starvation; worst-case wait is 1 cycle.
- While reset is low: both waitrequest=1, s_read=s_write=0, s_address/s_data_out=0, m*_read_valid=0, prio=0, protocol_error=0, tag pipeline cleared.
- Read and write asserted together by the winner:
  - write issued, read dropped;
  - command counts as accepted;
  - protocol_error <= 1.
- Tag pipeline: LATENCY-stage shift register of {valid, id}, shifting every cycle.
  - Stage 0 loads {1, winner} when a read issues, else {0, x}.
  - The last stage is compared with s_read_valid in the cycle it is presented.
- Response routing (combinational):
  - mN_read_valid = s_read_valid & last.valid & (last.id==N).
  - m0_data_out = m1_data_out = s_data_in (broadcast).
  - Master-observed read latency = LATENCY cycles from its accepted read.
- Back-to-back reads, any interleaving of masters: each response is routed in issue order.
- Boundary conditions:
  - s_read_valid with last.valid=0 (orphan, including responses to reads issued before a reset) -> no master read_valid, protocol_error <= 1.
  - last.valid=1 without s_read_valid (missing response) -> tag discarded, protocol_error <= 1.
  - protocol_error stays high until reset.
- Reset mid-operation: all in-flight tags are lost; the responses that follow are treated as orphans.

Test Plan:
1. m0 write addr 0x10 data 0xDEADBEEF, m1 idle -> same cycle s_write=1, s_address=0x10, s_data_out=0xDEADBEEF, m0_waitrequest=0.
2. Out of reset, m0 read 0x01 and m1 read 0x02 in the same cycle, LATENCY=1, peripheral returns 0xA1 then 0xB2 -> m0 issued cycle 0 (m1_waitrequest=1), m1 issued cycle 1; m0_read_valid with 0xA1 in cycle 1, m1_read_valid with 0xB2 in cycle 2.
3. Both masters write continuously for 6 cycles -> s_write every cycle, grants 0,1,0,1,0,1, each master's waitrequest high on alternate cycles.
4. LATENCY=3, reads m1,m0,m1 on consecutive cycles -> read_valid pulses m1,m0,m1 on cycles 3,4,5, no error.
5. s_read_valid=1 with no read outstanding -> m0/m1_read_valid stay 0, protocol_error=1 and holds until reset low.
6. m1 read in flight, reset pulsed low one cycle, response arrives after release -> no master read_valid, protocol_error=1; separately, m1_read=m1_write=1 -> only s_write=1, protocol_error=1.
